// File: rtl/croyde_mem_arbiter.sv
// Two-master arbiter sharing one memory port between fetch (imem) and load/store (dmem).
// dmem has fixed priority; a saturating wait counter lets a starved fetch win.
//
// state  | meaning
// IDLE   | no request outstanding, selection is combinational
// LOCK_I | imem request presented but not yet accepted, imem held selected
// LOCK_D | dmem request presented but not yet accepted, dmem held selected
module croyde_mem_arbiter #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = 8,
    parameter int MAX_STARVE = 4
) (
    input  logic                  g_clk,
    input  logic                  g_reset,

    input  logic                  imem_req,
    input  logic [MEM_ADDR_W-1:0] imem_addr,
    input  logic                  imem_wen,
    input  logic [MEM_STRB_W-1:0] imem_strb,
    input  logic [MEM_DATA_W-1:0] imem_wdata,
    output logic                  imem_gnt,
    output logic                  imem_err,
    output logic [MEM_DATA_W-1:0] imem_rdata,

    input  logic                  dmem_req,
    input  logic [MEM_ADDR_W-1:0] dmem_addr,
    input  logic                  dmem_wen,
    input  logic [MEM_STRB_W-1:0] dmem_strb,
    input  logic [MEM_DATA_W-1:0] dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_err,
    output logic [MEM_DATA_W-1:0] dmem_rdata,

    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [MEM_STRB_W-1:0] mem_strb,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_err,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2} lock_state_t;
    typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_I = 2'd1, SEL_D = 2'd2} sel_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    lock_state_t lock_state;
    lock_state_t lock_next;
    sel_t        sel;
    sel_t        rsp_sel;
    logic [3:0]  starve_cnt;
    logic        sel_req;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lock_state <= IDLE;
            rsp_sel    <= SEL_NONE;
            starve_cnt <= '0;
        end else begin
            lock_state <= lock_next;
            rsp_sel    <= (mem_req && mem_gnt) ? sel : SEL_NONE;
            if (imem_req && !imem_gnt) begin
                if (starve_cnt < STARVE_LIMIT)
                    starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Selection is forced to none during reset so every output reads 0.
    always_comb begin
        sel       = SEL_NONE;
        sel_req   = 1'b0;
        lock_next = lock_state;
        if (!g_reset) begin
            unique case (lock_state)
                LOCK_I: begin
                    sel     = SEL_I;
                    sel_req = imem_req;
                    if (mem_gnt)
                        lock_next = IDLE;
                end
                LOCK_D: begin
                    sel     = SEL_D;
                    sel_req = dmem_req;
                    if (mem_gnt)
                        lock_next = IDLE;
                end
                default: begin
                    if (imem_req && starve_cnt == STARVE_LIMIT)
                        sel = SEL_I;
                    else if (dmem_req)
                        sel = SEL_D;
                    else if (imem_req)
                        sel = SEL_I;
                    sel_req = (sel != SEL_NONE);
                    if (sel_req && !mem_gnt)
                        lock_next = (sel == SEL_I) ? LOCK_I : LOCK_D;
                end
            endcase
        end
    end

    always_comb begin
        mem_req   = sel_req;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_wdata = '0;
        if (sel == SEL_I) begin
            mem_addr  = imem_addr;
            mem_wen   = imem_wen;
            mem_strb  = imem_strb;
            mem_wdata = imem_wdata;
        end else if (sel == SEL_D) begin
            mem_addr  = dmem_addr;
            mem_wen   = dmem_wen;
            mem_strb  = dmem_strb;
            mem_wdata = dmem_wdata;
        end
    end

    assign imem_gnt   = mem_gnt && (sel == SEL_I);
    assign dmem_gnt   = mem_gnt && (sel == SEL_D);
    assign imem_rdata = (rsp_sel == SEL_I) ? mem_rdata : '0;
    assign imem_err   = (rsp_sel == SEL_I) && mem_err;
    assign dmem_rdata = (rsp_sel == SEL_D) ? mem_rdata : '0;
    assign dmem_err   = (rsp_sel == SEL_D) && mem_err;

`ifndef SYNTHESIS
    // dmem transfers accepted while a fetch is kept waiting.
    logic [4:0] dmem_xfers_waiting;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset)
            dmem_xfers_waiting <= '0;
        else if (imem_req && !imem_gnt)
            dmem_xfers_waiting <= dmem_xfers_waiting + {4'd0, dmem_gnt};
        else
            dmem_xfers_waiting <= '0;
    end

    a_mem_stable: assert property (@(posedge g_clk) disable iff (g_reset)
        (mem_req && !mem_gnt) |=> (mem_req && $stable({mem_addr, mem_wen, mem_strb, mem_wdata})));
    a_gnt_onehot: assert property (@(posedge g_clk) disable iff (g_reset)
        !(imem_gnt && dmem_gnt));
    a_fetch_bound: assert property (@(posedge g_clk) disable iff (g_reset)
        dmem_xfers_waiting <= 5'(MAX_STARVE));
    a_lock_i_held: assert property (@(posedge g_clk) disable iff (g_reset)
        (lock_state == LOCK_I) |-> imem_req);
    a_lock_d_held: assert property (@(posedge g_clk) disable iff (g_reset)
        (lock_state == LOCK_D) |-> dmem_req);
`endif

endmodule

// File: tb/tb_croyde_mem_arbiter.sv
// Scoreboard bench for croyde_mem_arbiter: a cycle-level reference model queues
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_croyde_mem_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SW   = 8;
    localparam int MAXS = 4;

    logic          g_clk = 1'b0;
    logic          g_reset;
    logic          imem_req, imem_wen, imem_gnt, imem_err;
    logic [AW-1:0] imem_addr;
    logic [SW-1:0] imem_strb;
    logic [DW-1:0] imem_wdata, imem_rdata;
    logic          dmem_req, dmem_wen, dmem_gnt, dmem_err;
    logic [AW-1:0] dmem_addr;
    logic [SW-1:0] dmem_strb;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          mem_req, mem_wen, mem_gnt, mem_err;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata, mem_rdata;

    croyde_mem_arbiter #(
        .MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW), .MAX_STARVE(MAXS)
    ) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
        .imem_strb(imem_strb), .imem_wdata(imem_wdata),
        .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic          mreq;
        logic [AW-1:0] maddr;
        logic          mwen;
        logic [SW-1:0] mstrb;
        logic [DW-1:0] mwdata;
        logic          gi;
        logic          gd;
        logic          ierr;
        logic [DW-1:0] irdata;
        logic          derr;
        logic [DW-1:0] drdata;
        logic [3:0]    starve;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: owner 0=none 1=imem 2=dmem; wait counts fetch wait cycles.
    int   m_owner = 0;
    int   m_wait  = 0;
    int   m_resp  = 0;
    logic exp_gi  = 1'b0;
    logic exp_gd  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_cycle();
        exp_t e;
        int   sel;
        e = '0;
        if (g_reset) begin
            m_owner = 0;
            m_wait  = 0;
            m_resp  = 0;
            exp_gi  = 1'b0;
            exp_gd  = 1'b0;
        end else begin
            if (m_owner != 0)                  sel = m_owner;
            else if (imem_req && m_wait >= MAXS) sel = 1;
            else if (dmem_req)                 sel = 2;
            else if (imem_req)                 sel = 1;
            else                               sel = 0;
            if (sel == 1) begin
                e.mreq = imem_req; e.maddr = imem_addr; e.mwen = imem_wen;
                e.mstrb = imem_strb; e.mwdata = imem_wdata;
            end else if (sel == 2) begin
                e.mreq = dmem_req; e.maddr = dmem_addr; e.mwen = dmem_wen;
                e.mstrb = dmem_strb; e.mwdata = dmem_wdata;
            end
            e.gi = mem_gnt && (sel == 1);
            e.gd = mem_gnt && (sel == 2);
            if (m_resp == 1) begin e.irdata = mem_rdata; e.ierr = mem_err; end
            if (m_resp == 2) begin e.drdata = mem_rdata; e.derr = mem_err; end
            e.starve = 4'(m_wait);
            m_resp = (e.mreq && mem_gnt) ? sel : 0;
            if (m_owner == 0) begin
                if (e.mreq && !mem_gnt) m_owner = sel;
            end else if (mem_gnt) begin
                m_owner = 0;
            end
            m_wait = (imem_req && !e.gi) ? ((m_wait < MAXS) ? m_wait + 1 : MAXS) : 0;
            exp_gi = e.gi;
            exp_gd = e.gd;
        end
        exp_q.push_back(e);
    endtask

    // Request fields derive from the address so a held request stays stable.
    task automatic step(input logic rst, input logic ir, input logic [63:0] ia,
                        input logic dr, input logic [63:0] da, input logic mg,
                        input logic [63:0] rd, input logic er);
        @(posedge g_clk);
        #1;
        g_reset    = rst;
        imem_req   = ir;
        imem_addr  = ia;
        imem_wen   = ia[3];
        imem_strb  = ia[15:8];
        imem_wdata = ia ^ 64'hA5A5_5A5A_0F0F_F0F0;
        dmem_req   = dr;
        dmem_addr  = da;
        dmem_wen   = da[3];
        dmem_strb  = da[15:8];
        dmem_wdata = da ^ 64'h3C3C_C3C3_1234_8765;
        mem_gnt    = mg;
        mem_rdata  = rd;
        mem_err    = er;
        model_cycle();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin : monitor
        exp_t e;
        int   dx;
        dx = 0;
        forever begin
            @(negedge g_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_req",    64'(mem_req),    64'(e.mreq));
                chk("mem_addr",   mem_addr,        e.maddr);
                chk("mem_wen",    64'(mem_wen),    64'(e.mwen));
                chk("mem_strb",   64'(mem_strb),   64'(e.mstrb));
                chk("mem_wdata",  mem_wdata,       e.mwdata);
                chk("imem_gnt",   64'(imem_gnt),   64'(e.gi));
                chk("dmem_gnt",   64'(dmem_gnt),   64'(e.gd));
                chk("imem_err",   64'(imem_err),   64'(e.ierr));
                chk("imem_rdata", imem_rdata,      e.irdata);
                chk("dmem_err",   64'(dmem_err),   64'(e.derr));
                chk("dmem_rdata", dmem_rdata,      e.drdata);
                chk("starve_cnt", 64'(dut.starve_cnt), 64'(e.starve));
            end
            // Fetch must never wait behind more than MAXS dmem transfers.
            if (g_reset || !imem_req) begin
                dx = 0;
            end else if (imem_gnt) begin
                n_checks++;
                if (dx > MAXS) begin
                    n_fail++;
                    $display("FAIL fetch_bound actual=%0d dmem transfers required<=%0d t=%0t", dx, MAXS, $time);
                end
                dx = 0;
            end else if (dmem_gnt) begin
                dx++;
            end
        end
    end

    initial begin : stim
        logic          ir, dr;
        logic [63:0]   ia, da;
        g_reset = 1'b1;
        imem_req = 1'b0; imem_addr = '0; imem_wen = 1'b0; imem_strb = '0; imem_wdata = '0;
        dmem_req = 1'b0; dmem_addr = '0; dmem_wen = 1'b0; dmem_strb = '0; dmem_wdata = '0;
        mem_gnt = 1'b0; mem_rdata = '0; mem_err = 1'b0;

        // Reset held with everything requesting, then contention at full downstream rate.
        ia = 64'h0000_0000_0000_0100;
        da = 64'h0000_0000_0000_0200;
        repeat (3) step(1'b1, 1'b1, ia, 1'b1, da, 1'b1, rnd64(), 1'b1);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b1, ia, 1'b1, da, 1'b1, rnd64(), 1'($urandom_range(0, 1)));
            if (exp_gi) ia = rnd64();
            if (exp_gd) da = rnd64();
        end
        repeat (2) step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, rnd64(), 1'b0);

        // Lock hold: fetch at 0x1000 stalls three cycles while dmem arrives.
        step(1'b0, 1'b1, 64'h1000, 1'b0, 64'h2000, 1'b0, rnd64(), 1'b0);
        step(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, rnd64(), 1'b0);
        step(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, rnd64(), 1'b0);
        step(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, rnd64(), 1'b0);
        step(1'b0, 1'b0, 64'h0,    1'b1, 64'h2000, 1'b1, rnd64(), 1'b0);
        step(1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, rnd64(), 1'b1);

        // Response routing: D then I on consecutive cycles.
        step(1'b0, 1'b1, 64'h3000, 1'b1, 64'h4000, 1'b1, rnd64(), 1'b1);
        step(1'b0, 1'b1, 64'h3000, 1'b0, 64'h0,    1'b1, 64'hAAAA, 1'b0);
        step(1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h5555, 1'b1);
        step(1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, rnd64(), 1'b1);

        // Reset pulse while dmem is locked: the pending transfer must vanish.
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h5008, 1'b0, rnd64(), 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h5008, 1'b0, rnd64(), 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, rnd64(), 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, rnd64(), 1'b1);

        // Idle.
        repeat (10) step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'($urandom_range(0, 1)),
                         rnd64(), 1'($urandom_range(0, 1)));

        // Random traffic with a stalling downstream.
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0;
        for (int c = 0; c < 600; c++) begin
            if (!ir || exp_gi) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = rnd64();
            end
            if (!dr || exp_gd) begin
                dr = ($urandom_range(0, 3) != 0);
                da = rnd64();
            end
            step(1'b0, ir, ia, dr, da, ($urandom_range(0, 99) < 60), rnd64(),
                 1'($urandom_range(0, 1)));
        end
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, rnd64(), 1'b0);

        @(negedge g_clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d entries required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
